traffic_lamp_driver: RTL and testbench
======================================

# traffic_lamp_driver

Output stage placed after the traffic light controller. Takes the controller's four 2-bit light codes (car lights A/B, pedestrian lights PA/PB), generates the blink timing, and drives the individual lamp lines. It also acts as an independent conflict monitor. If it sees an unsafe or illegal code combination that persists, it latches a fault and forces a safe flashing pattern until software clears it.

## Interface
- BLINK_HALF, 4: CLK cycles per blink half-period (≥1).
- CONFLICT_CYCLES, 2: consecutive illegal samples required to latch a fault (≥1).
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- A, B  in  2 each  car light codes: 00 RED, 01 YELLOW, 10 GREEN, 11 BLINKING_RED.
- PA, PB  in  2 each  pedestrian light codes, same encoding; 01 is illegal here.
- CLR_FAULT  in  1  fault clear request, level, sampled each edge.
- A_LAMP, B_LAMP  out  3 each  {R,Y,G} lamp enables.
- PA_LAMP, PB_LAMP  out  2 each  {R,G} lamp enables.
- FAULT  out  1  fault latched.
- FAULT_CODE  out  3  {illegal_ped_code, car_ped_conflict, car_car_conflict}, captured at latch.

## Operation
- Decode: RED→R, YELLOW→Y, GREEN→G, BLINKING_RED→R=blink_on.
  - Car: {1,0,0}, {0,1,0}, {0,0,1}, {blink_on,0,0}.
  - Ped: RED {1,0}, GREEN {0,1}, BLINKING_RED {blink_on,0}.
- Illegal sample: any of the following.
  - car_car: A∈{YELLOW,GREEN} and B∈{YELLOW,GREEN}.
  - car_ped: (A∈{YELLOW,GREEN} and PA=GREEN) or (B∈{YELLOW,GREEN} and PB=GREEN).
  - illegal_ped_code: PA=01 or PB=01.
- Blink generator: free-running counter 0..BLINK_HALF-1.
  - On the edge where the count is BLINK_HALF-1, the counter goes to 0 and blink_on toggles.
  - The generator is independent of the FSM state.
- FSM states: NORMAL, PENDING, LATCHED.
  - NORMAL, legal sample: stay; lamps = decode.
  - NORMAL, illegal sample: PENDING with pend_cnt=1. If CONFLICT_CYCLES=1, go directly to LATCHED.
  - PENDING, illegal sample: pend_cnt+1. When pend_cnt reaches CONFLICT_CYCLES, go to LATCHED.
  - PENDING, legal sample: NORMAL; lamps = decode of that sample; pend_cnt=0.
  - PENDING lamp output: all lamps solid red, i.e. car {1,0,0}, ped {1,0}.
  - LATCHED: FAULT=1.
    - Car lamps {blink_on,0,0}; ped lamps {1,0}.
    - FAULT_CODE = OR of the three conflict flags on the latching sample; held constant while LATCHED.
  - LATCHED exit: leave only when CLR_FAULT=1 and the same sample is legal. Then go to NORMAL with FAULT=0 and FAULT_CODE=000, and lamps decode that sample.
  - CLR_FAULT with an illegal sample: ignored.
  - CLR_FAULT in NORMAL or PENDING: ignored.
- pend_cnt width: $clog2(CONFLICT_CYCLES+1); it saturates, no wrap.

## Timing
- All outputs are registered. Input codes sampled at edge k appear on the outputs after edge k (1-cycle latency).
- Lamp values at edge k use the blink_on value held before edge k.
- Any illegal sample gives all-red on the very next output. It never shows a decoded unsafe pattern.
- FAULT rises after the edge that samples the CONFLICT_CYCLES-th consecutive illegal sample.
- Reset values:
  - A_LAMP=B_LAMP=100, PA_LAMP=PB_LAMP=10.
  - FAULT=0, FAULT_CODE=000.
  - State NORMAL, pend_cnt=0, blink counter=0, blink_on=1.
- RST has priority over everything. Asserting it mid-fault or mid-PENDING returns all registers to their reset values on that edge.

## Structure
- Package traffic_pkg:
  - Light codes RED/YELLOW/GREEN/BLINKING_RED.
  - Lamp bit indices LAMP_R/LAMP_Y/LAMP_G.
  - FAULT_CODE bit indices.
  - FSM state encoding.
- Sub-module blink_gen (parameter BLINK_HALF; ports CLK, RST, blink_on).
- Decode, conflict check and FSM live in the top module.

## Test plan
1. Reset: hold RST 2 cycles → lamps 100/100/10/10, FAULT=0, FAULT_CODE=000.
2. Legal decode: A=10, B=00, PA=00, PB=10 → one edge later A_LAMP=001, B_LAMP=100, PA_LAMP=10, PB_LAMP=01.
3. Blink: BLINK_HALF=4, PB=11 held → PB_LAMP alternates 10 ×4 cycles, 00 ×4 cycles, phase-locked to the reset release.
4. Transient conflict: A=B=10 for 1 cycle, then legal → all-red for 1 cycle, FAULT stays 0, decode resumes.
5. Latched fault: A=10, PA=10 for 2 cycles → FAULT=1, FAULT_CODE=010, car lamps flash red, ped lamps 10.
   - Then CLR_FAULT=1 with the conflict still present → still LATCHED.
   - Then legal codes with CLR_FAULT=1 → FAULT=0, lamps decode.
6. PA=01 for 2 cycles → FAULT_CODE=100. Assert RST while LATCHED → all reset values after that edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, lamp/fault bit indices, FSM states and lamp decoders
package traffic_pkg;
  typedef enum logic [1:0] {RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10, BLINKING_RED = 2'b11} light_t;
  typedef enum logic [1:0] {NORMAL = 2'b00, PENDING = 2'b01, LATCHED = 2'b10} state_t;
  localparam int LAMP_R = 2;
  localparam int LAMP_Y = 1;
  localparam int LAMP_G = 0;
  localparam int PED_R = 1;
  localparam int PED_G = 0;
  localparam int FC_PED = 2;
  localparam int FC_CAR_PED = 1;
  localparam int FC_CAR_CAR = 0;
  function automatic logic [2:0] car_dec(input logic [1:0] c, input logic b);
    car_dec = '0;
    car_dec[LAMP_R] = c == RED || (c == BLINKING_RED && b);
    car_dec[LAMP_Y] = c == YELLOW;
    car_dec[LAMP_G] = c == GREEN;
  endfunction
  // the pedestrian YELLOW code is illegal; it decodes to red so nothing unsafe can ever show
  function automatic logic [1:0] ped_dec(input logic [1:0] c, input logic b);
    ped_dec = '0;
    ped_dec[PED_R] = c == RED || c == YELLOW || (c == BLINKING_RED && b);
    ped_dec[PED_G] = c == GREEN;
  endfunction
endpackage

// File: rtl/blink_gen.sv
// blink_gen: free-running blink phase, toggles every BLINK_HALF cycles, starts on
module blink_gen #(
  parameter int BLINK_HALF = 4
) (
  input  logic CLK,
  input  logic RST,
  output logic blink_on
);
  localparam int CW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(BLINK_HALF - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      blink_on <= 1'b1;
    end else begin
      cnt      <= wrap ? '0 : cnt + 1'b1;
      blink_on <= wrap ? ~blink_on : blink_on;
    end
  end
endmodule

// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver: decodes light codes to lamps and latches a flashing-red fault on persistent conflicts
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int BLINK_HALF      = 4,
  parameter int CONFLICT_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] PA,
  input  logic [1:0] PB,
  input  logic       CLR_FAULT,
  output logic [2:0] A_LAMP,
  output logic [2:0] B_LAMP,
  output logic [1:0] PA_LAMP,
  output logic [1:0] PB_LAMP,
  output logic       FAULT,
  output logic [2:0] FAULT_CODE
);
  localparam int PW = $clog2(CONFLICT_CYCLES + 1);
  state_t state, state_nx;
  logic [PW-1:0] pend_cnt, pend_nx, pend_inc;
  logic [2:0] code_nx, flags, a_nx, b_nx;
  logic [1:0] pa_nx, pb_nx;
  logic blink_on, a_act, b_act, bad;
  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .CLK     (CLK),
    .RST     (RST),
    .blink_on(blink_on)
  );
  always_comb begin
    a_act = A == YELLOW || A == GREEN;
    b_act = B == YELLOW || B == GREEN;
    flags = '0;
    flags[FC_CAR_CAR] = a_act && b_act;
    flags[FC_CAR_PED] = (a_act && PA == GREEN) || (b_act && PB == GREEN);
    flags[FC_PED] = PA == YELLOW || PB == YELLOW;
    bad = |flags;
    pend_inc = pend_cnt == PW'(CONFLICT_CYCLES) ? pend_cnt : pend_cnt + 1'b1;
    state_nx = state;
    pend_nx = pend_cnt;
    case (state)
      NORMAL: begin
        state_nx = bad ? (CONFLICT_CYCLES == 1 ? LATCHED : PENDING) : NORMAL;
        pend_nx = bad ? PW'(1) : '0;
      end
      PENDING: begin
        state_nx = !bad ? NORMAL : pend_inc == PW'(CONFLICT_CYCLES) ? LATCHED : PENDING;
        pend_nx = bad ? pend_inc : '0;
      end
      LATCHED: begin
        state_nx = CLR_FAULT && !bad ? NORMAL : LATCHED;
        pend_nx = CLR_FAULT && !bad ? '0 : pend_cnt;
      end
      default: begin
        state_nx = NORMAL;
        pend_nx = '0;
      end
    endcase
    // the code is frozen for the whole fault, captured only on the latching sample
    code_nx = state_nx == NORMAL ? 3'b000 :
              state != LATCHED && state_nx == LATCHED ? flags : FAULT_CODE;
    a_nx  = state_nx == NORMAL ? car_dec(A, blink_on) : state_nx == PENDING ? 3'b100 : {blink_on, 2'b00};
    b_nx  = state_nx == NORMAL ? car_dec(B, blink_on) : state_nx == PENDING ? 3'b100 : {blink_on, 2'b00};
    pa_nx = state_nx == NORMAL ? ped_dec(PA, blink_on) : 2'b10;
    pb_nx = state_nx == NORMAL ? ped_dec(PB, blink_on) : 2'b10;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= NORMAL;
      pend_cnt   <= '0;
      A_LAMP     <= 3'b100;
      B_LAMP     <= 3'b100;
      PA_LAMP    <= 2'b10;
      PB_LAMP    <= 2'b10;
      FAULT      <= 1'b0;
      FAULT_CODE <= 3'b000;
    end else begin
      state      <= state_nx;
      pend_cnt   <= pend_nx;
      A_LAMP     <= a_nx;
      B_LAMP     <= b_nx;
      PA_LAMP    <= pa_nx;
      PB_LAMP    <= pb_nx;
      FAULT      <= state_nx == LATCHED;
      FAULT_CODE <= code_nx;
    end
  end
endmodule

// File: tb/tb_traffic_lamp_driver.sv
// tb_traffic_lamp_driver: directed vectors with hand-computed lamp and fault expectations
module tb_traffic_lamp_driver;
  import traffic_pkg::*;
  logic CLK = 1'b0, RST = 1'b1, CLR_FAULT = 1'b0;
  logic [1:0] A = RED, B = RED, PA = RED, PB = RED;
  logic [2:0] A_LAMP, B_LAMP, FAULT_CODE;
  logic [1:0] PA_LAMP, PB_LAMP;
  logic FAULT;
  int checks = 0, errors = 0, k = 0;
  traffic_lamp_driver #(.BLINK_HALF(4), .CONFLICT_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .PA(PA), .PB(PB), .CLR_FAULT(CLR_FAULT),
    .A_LAMP(A_LAMP), .B_LAMP(B_LAMP), .PA_LAMP(PA_LAMP), .PB_LAMP(PB_LAMP),
    .FAULT(FAULT), .FAULT_CODE(FAULT_CODE)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, obs, exp, k);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
    k = RST ? 0 : k + 1;
  endtask
  // blink_on before edge k after reset release: on for edges 1..4, off for 5..8, ...
  function automatic logic bon(input int e);
    return ((e - 1) / 4) % 2 == 0;
  endfunction
  task automatic set(input logic [1:0] a, input logic [1:0] b, input logic [1:0] pa, input logic [1:0] pb);
    A = a; B = b; PA = pa; PB = pb;
  endtask
  task automatic lamps(input string tag, input logic [2:0] a, input logic [2:0] b, input logic [1:0] pa, input logic [1:0] pb);
    chk({tag, "_a"}, 8'(A_LAMP), 8'(a));
    chk({tag, "_b"}, 8'(B_LAMP), 8'(b));
    chk({tag, "_pa"}, 8'(PA_LAMP), 8'(pa));
    chk({tag, "_pb"}, 8'(PB_LAMP), 8'(pb));
  endtask
  task automatic fault(input string tag, input logic f, input logic [2:0] c);
    chk({tag, "_fault"}, 8'(FAULT), 8'(f));
    chk({tag, "_code"}, 8'(FAULT_CODE), 8'(c));
  endtask
  initial begin
    tick(); tick();
    lamps("reset", 3'b100, 3'b100, 2'b10, 2'b10);
    fault("reset", 1'b0, 3'b000);
    RST = 1'b0;
    set(GREEN, RED, RED, GREEN);
    tick();
    lamps("decode", 3'b001, 3'b100, 2'b10, 2'b01);
    fault("decode", 1'b0, 3'b000);
    set(GREEN, RED, RED, BLINKING_RED);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("blink_pb", 8'(PB_LAMP), bon(k) ? 8'b10 : 8'b00);
    end
    set(GREEN, GREEN, RED, RED);
    tick();
    lamps("transient", 3'b100, 3'b100, 2'b10, 2'b10);
    fault("transient", 1'b0, 3'b000);
    set(RED, GREEN, GREEN, RED);
    tick();
    lamps("resume", 3'b100, 3'b001, 2'b01, 2'b10);
    fault("resume", 1'b0, 3'b000);
    set(GREEN, RED, GREEN, RED);
    tick();
    lamps("pending", 3'b100, 3'b100, 2'b10, 2'b10);
    fault("pending", 1'b0, 3'b000);
    tick();
    fault("latch", 1'b1, 3'b010);
    for (int i = 0; i < 6; i++) begin
      lamps("flash", {bon(k), 2'b00}, {bon(k), 2'b00}, 2'b10, 2'b10);
      set(i[0] ? RED : GREEN, RED, RED, RED);
      tick();
      fault("held", 1'b1, 3'b010);
    end
    set(GREEN, RED, GREEN, RED);
    CLR_FAULT = 1'b1;
    tick();
    fault("clr_bad", 1'b1, 3'b010);
    set(GREEN, RED, RED, GREEN);
    tick();
    fault("clr_ok", 1'b0, 3'b000);
    lamps("clr_ok", 3'b001, 3'b100, 2'b10, 2'b01);
    tick();
    fault("clr_normal", 1'b0, 3'b000);
    CLR_FAULT = 1'b0;
    set(RED, RED, YELLOW, RED);
    tick();
    lamps("ped_pend", 3'b100, 3'b100, 2'b10, 2'b10);
    tick();
    fault("ped_latch", 1'b1, 3'b100);
    RST = 1'b1;
    tick();
    lamps("rst_fault", 3'b100, 3'b100, 2'b10, 2'b10);
    fault("rst_fault", 1'b0, 3'b000);
    RST = 1'b0;
    set(GREEN, YELLOW, GREEN, YELLOW);
    tick();
    fault("multi_pend", 1'b0, 3'b000);
    tick();
    fault("multi_latch", 1'b1, 3'b111);
    lamps("multi_flash", {bon(k), 2'b00}, {bon(k), 2'b00}, 2'b10, 2'b10);
    set(RED, RED, RED, BLINKING_RED);
    CLR_FAULT = 1'b1;
    tick();
    fault("multi_clr", 1'b0, 3'b000);
    chk("rst_blink_phase", 8'(PB_LAMP), bon(k) ? 8'b10 : 8'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
